// File: rtl/utils_pkg.sv
// Shared AXI4 bus types plus the state enum and helpers used by the
// single-outstanding core-to-AXI master.
package utils_pkg;

  localparam int AXI_AW  = 32;
  localparam int AXI_DW  = 32;
  localparam int AXI_IDW = 4;

  typedef enum logic [2:0] {
    AXI_BYTE      = 3'd0,
    AXI_HALF_WORD = 3'd1,
    AXI_WORD      = 3'd2
  } axi_size_t;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'd0,
    AXI_EXOKAY = 2'd1,
    AXI_SLVERR = 2'd2,
    AXI_DECERR = 2'd3
  } axi_resp_t;

  typedef enum logic [1:0] {
    AXI_FIXED = 2'd0,
    AXI_INCR  = 2'd1,
    AXI_WRAP  = 2'd2
  } axi_burst_t;

  typedef enum logic [2:0] {
    MST_IDLE,
    MST_WR,
    MST_WR_RESP,
    MST_RD_ADDR,
    MST_RD_DATA,
    MST_RESP
  } axi_mst_st_t;

  typedef struct packed {
    logic [AXI_IDW-1:0] awid;
    logic [AXI_AW-1:0]  awaddr;
    logic [7:0]         awlen;
    axi_size_t          awsize;
    axi_burst_t         awburst;
    logic               awlock;
    logic [3:0]         awcache;
    logic [2:0]         awprot;
    logic [3:0]         awqos;
    logic [3:0]         awregion;
    logic               awuser;
    logic               awvalid;
    logic [AXI_DW-1:0]  wdata;
    logic [3:0]         wstrb;
    logic               wlast;
    logic               wuser;
    logic               wvalid;
    logic               bready;
    logic [AXI_IDW-1:0] arid;
    logic [AXI_AW-1:0]  araddr;
    logic [7:0]         arlen;
    axi_size_t          arsize;
    axi_burst_t         arburst;
    logic               arlock;
    logic [3:0]         arcache;
    logic [2:0]         arprot;
    logic [3:0]         arqos;
    logic [3:0]         arregion;
    logic               aruser;
    logic               arvalid;
    logic               rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic               awready;
    logic               wready;
    logic [AXI_IDW-1:0] bid;
    axi_resp_t          bresp;
    logic               bvalid;
    logic               arready;
    logic [AXI_IDW-1:0] rid;
    logic [AXI_DW-1:0]  rdata;
    axi_resp_t          rresp;
    logic               rlast;
    logic               rvalid;
  } s_axi_miso_t;

  function automatic logic [3:0] axi_size_to_strb(axi_size_t size);
    case (size)
      AXI_BYTE:      return 4'b0001;
      AXI_HALF_WORD: return 4'b0011;
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] axi_align_rd(
    logic [31:0] data,
    logic [1:0]  byte_sel,
    axi_size_t   size
  );
    logic [31:0] sh;
    sh = data >> {byte_sel, 3'b000};
    case (size)
      AXI_BYTE:      return {24'h0, sh[7:0]};
      AXI_HALF_WORD: return {16'h0, sh[15:0]};
      default:       return sh;
    endcase
  endfunction

  function automatic logic axi_misaligned(
    logic [1:0] addr_lo,
    axi_size_t  size
  );
    case (size)
      AXI_HALF_WORD: return addr_lo[0];
      AXI_WORD:      return |addr_lo;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axi_simple_master.sv
// Core load/store port to single-beat AXI4 master, one transfer
// outstanding, with strobes, read alignment and response timeout.
module axi_simple_master
  import utils_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  axi_size_t   req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
);

  localparam int unsigned CW =
    (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  axi_mst_st_t   state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  axi_size_t     size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          arvalid_q, arvalid_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic aw_hs, w_hs, ar_hs, tmo_hit;
  logic unused_miso;

  assign aw_hs = awvalid_q & axi_miso.awready;
  assign w_hs  = wvalid_q & axi_miso.wready;
  assign ar_hs = arvalid_q & axi_miso.arready;
  assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == TMO_LAST);
  assign unused_miso = ^{axi_miso.bid, axi_miso.rid, axi_miso.rlast};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      MST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          if (axi_misaligned(req_addr[1:0], req_size)) begin
            state_d     = MST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d   = MST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = MST_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      MST_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d = MST_WR_RESP;
          cnt_d   = '0;
        end
      end
      MST_WR_RESP: begin
        if (axi_miso.bvalid) begin
          state_d     = MST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = (axi_miso.bresp != AXI_OKAY);
        end else if (tmo_hit) begin
          state_d     = MST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MST_RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = MST_RD_DATA;
          cnt_d     = '0;
        end
      end
      MST_RD_DATA: begin
        if (axi_miso.rvalid) begin
          state_d     = MST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = axi_align_rd(axi_miso.rdata,
                                     addr_q[1:0], size_q);
          rsp_err_d   = (axi_miso.rresp != AXI_OKAY);
        end else if (tmo_hit) begin
          state_d     = MST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MST_RESP: begin
        if (rsp_ready) begin
          state_d     = MST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = MST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MST_IDLE;
      addr_q      <= '0;
      size_q      <= AXI_BYTE;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == MST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Every bus field comes straight from a flop or is constant.
  always_comb begin
    axi_mosi         = '0;
    axi_mosi.awaddr  = addr_q;
    axi_mosi.awsize  = size_q;
    axi_mosi.awburst = AXI_INCR;
    axi_mosi.awvalid = awvalid_q;
    axi_mosi.wdata   = wdata_q;
    axi_mosi.wstrb   = axi_size_to_strb(size_q);
    axi_mosi.wlast   = 1'b1;
    axi_mosi.wvalid  = wvalid_q;
    axi_mosi.bready  = 1'b1;
    axi_mosi.araddr  = addr_q;
    axi_mosi.arsize  = size_q;
    axi_mosi.arburst = AXI_INCR;
    axi_mosi.arvalid = arvalid_q;
    axi_mosi.rready  = 1'b1;
  end

endmodule

// File: tb/tb_axi_simple_master.sv
// Directed bench for axi_simple_master with a small behavioural AXI
// slave that has stall, mute and late-response knobs.
module tb_axi_simple_master;
  import utils_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  axi_size_t   req_size = AXI_WORD;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_simple_master #(.TIMEOUT_CYC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .axi_mosi  (mosi),
    .axi_miso  (miso)
  );

  int   aw_stall = 0;
  logic r_mute = 1'b0;
  logic b_mute = 1'b0;
  logic r_inject = 1'b0;

  logic [31:0] mem [0:63];
  int          aw_wait;
  logic        aw_got, w_got, bvalid_q, rvalid_q;
  logic [31:0] rdata_q, awaddr_s, wdata_s;
  logic [3:0]  wstrb_s, s_strb;
  logic [31:0] s_data;
  int          cyc = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
  int          aw_cyc = 0, w_cyc = 0;
  logic [7:0]  last_awlen = '0;
  axi_size_t   last_awsize = AXI_BYTE, last_arsize = AXI_BYTE;
  axi_burst_t  last_awburst = AXI_FIXED;
  logic        aw_hs, w_hs, ar_hs;

  assign aw_hs  = mosi.awvalid & miso.awready;
  assign w_hs   = mosi.wvalid & miso.wready;
  assign ar_hs  = mosi.arvalid & miso.arready;
  assign s_strb = wstrb_s << awaddr_s[1:0];
  assign s_data = wdata_s << {awaddr_s[1:0], 3'b000};

  always_comb begin
    miso         = '0;
    miso.awready = (aw_wait >= aw_stall);
    miso.wready  = 1'b1;
    miso.bvalid  = bvalid_q;
    miso.bresp   = AXI_OKAY;
    miso.arready = 1'b1;
    miso.rvalid  = rvalid_q | r_inject;
    miso.rdata   = r_inject ? 32'h5A5A5A5A : rdata_q;
    miso.rresp   = AXI_OKAY;
    miso.rlast   = 1'b1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_wait  <= 0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      awaddr_s <= '0;
      wdata_s  <= '0;
      wstrb_s  <= '0;
    end else begin
      cyc      <= cyc + 1;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      if (aw_hs) begin
        aw_got       <= 1'b1;
        awaddr_s     <= mosi.awaddr;
        aw_cnt       <= aw_cnt + 1;
        aw_cyc       <= cyc;
        aw_wait      <= 0;
        last_awsize  <= mosi.awsize;
        last_awlen   <= mosi.awlen;
        last_awburst <= mosi.awburst;
      end else if (mosi.awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_s <= mosi.wdata;
        wstrb_s <= mosi.wstrb;
        w_cnt   <= w_cnt + 1;
        w_cyc   <= cyc;
      end
      if (aw_got && w_got) begin
        for (int i = 0; i < 4; i++)
          if (s_strb[i]) mem[awaddr_s[7:2]][8*i +: 8] <= s_data[8*i +: 8];
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        bvalid_q <= !b_mute;
      end
      if (bvalid_q && mosi.bready) b_cnt <= b_cnt + 1;
      if (ar_hs) begin
        ar_cnt      <= ar_cnt + 1;
        last_arsize <= mosi.arsize;
        rvalid_q    <= !r_mute;
        rdata_q     <= mem[mosi.araddr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr,
                        input axi_size_t size, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rdata,
                        output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_wait_bound", 32'(rsp_valid), 1);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 1);
      chk("hold_rsp_rdata", rsp_rdata, rdata);
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, aw0, ar0, b0;

  initial begin
    #2;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_valids", {29'h0, mosi.awvalid, mosi.wvalid, mosi.arvalid}, 0);
    chk("rst_readies", {30'h0, mosi.bready, mosi.rready}, 32'h3);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    do_req(1'b1, 32'h10, AXI_WORD, 32'hDEADBEEF, 0, rd, er, lat);
    chk("sw_wstrb", 32'(wstrb_s), 32'hF);
    chk("sw_wdata", wdata_s, 32'hDEADBEEF);
    chk("sw_awsize", 32'(last_awsize), 32'(AXI_WORD));
    chk("sw_awlen", 32'(last_awlen), 0);
    chk("sw_awburst", 32'(last_awburst), 32'(AXI_INCR));
    chk("sw_err", 32'(er), 0);
    chk("sw_rdata", rd, 0);
    chk("sw_lat", lat, 4);

    do_req(1'b0, 32'h10, AXI_WORD, 0, 0, rd, er, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 0);
    chk("lw_lat", lat, 3);
    chk("lw_arsize", 32'(last_arsize), 32'(AXI_WORD));

    do_req(1'b1, 32'h13, AXI_BYTE, 32'h000000AB, 0, rd, er, lat);
    chk("sb_wstrb", 32'(wstrb_s), 32'h1);
    chk("sb_wdata", wdata_s, 32'hAB);
    chk("sb_err", 32'(er), 0);
    do_req(1'b0, 32'h13, AXI_BYTE, 0, 0, rd, er, lat);
    chk("lb_rdata", rd, 32'h000000AB);
    do_req(1'b0, 32'h10, AXI_WORD, 0, 0, rd, er, lat);
    chk("lw2_rdata", rd, 32'hABADBEEF);
    do_req(1'b0, 32'h12, AXI_HALF_WORD, 0, 3, rd, er, lat);
    chk("lh_rdata", rd, 32'h0000ABAD);
    chk("lh_err", 32'(er), 0);

    aw0 = aw_cnt;
    ar0 = ar_cnt;
    do_req(1'b0, 32'h21, AXI_HALF_WORD, 0, 0, rd, er, lat);
    chk("mis_h_err", 32'(er), 1);
    chk("mis_h_lat", lat, 1);
    chk("mis_h_rdata", rd, 0);
    do_req(1'b0, 32'h22, AXI_WORD, 0, 0, rd, er, lat);
    chk("mis_w_err", 32'(er), 1);
    chk("mis_w_lat", lat, 1);
    chk("mis_no_axi", aw_cnt + ar_cnt - aw0 - ar0, 0);

    aw_stall = 5;
    b0  = b_cnt;
    aw0 = aw_cnt;
    do_req(1'b1, 32'h18, AXI_WORD, 32'h5555AAAA, 0, rd, er, lat);
    aw_stall = 0;
    chk("stall_w_first", aw_cyc - w_cyc, 5);
    chk("stall_one_aw", aw_cnt - aw0, 1);
    chk("stall_one_b", b_cnt - b0, 1);
    chk("stall_err", 32'(er), 0);

    r_mute = 1'b1;
    do_req(1'b0, 32'h10, AXI_WORD, 0, 0, rd, er, lat);
    r_mute = 1'b0;
    chk("tmo_err", 32'(er), 1);
    chk("tmo_lat", lat, 10);
    chk("tmo_rdata", rd, 0);
    @(negedge clk);
    r_inject = 1'b1;
    @(negedge clk);
    r_inject = 1'b0;
    @(negedge clk);
    chk("late_r_rsp_valid", 32'(rsp_valid), 0);
    chk("late_r_req_ready", 32'(req_ready), 1);
    do_req(1'b0, 32'h18, AXI_WORD, 0, 0, rd, er, lat);
    chk("post_tmo_rdata", rd, 32'h5555AAAA);
    chk("post_tmo_err", 32'(er), 0);

    b_mute = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h14;
    req_size  = AXI_WORD;
    req_wdata = 32'h11112222;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_awvalid", 32'(mosi.awvalid), 1);
    @(negedge clk);
    chk("wr_resp_valids", {30'h0, mosi.awvalid, mosi.wvalid}, 0);
    chk("wr_resp_req_ready", 32'(req_ready), 0);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_valids",
        {29'h0, mosi.awvalid, mosi.wvalid, mosi.arvalid}, 0);
    chk("mid_rst_readies", {30'h0, mosi.bready, mosi.rready}, 32'h3);
    @(negedge clk);
    rst    = 1'b1;
    b_mute = 1'b0;
    do_req(1'b0, 32'h10, AXI_WORD, 0, 0, rd, er, lat);
    chk("post_rst_rdata", rd, 32'hABADBEEF);
    chk("post_rst_err", 32'(er), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
